// File: rtl/uart_rx.sv
// Oversampling UART receiver: 2-flop input synchronizer, start-bit validation at
// mid-bit, LSB-first data capture and stop-bit check with one-cycle result pulses.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e                 state_q, state_d;
  logic                   sync1_q, rx_s_q, rx_prev_q;
  logic [TICK_W-1:0]      tick_q, tick_d, tick_inc;
  logic [BIT_W-1:0]       bit_q, bit_d, bit_inc;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   data_valid_q, data_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   fall;

  assign tick_inc = tick_q + TICK_W'(1);
  assign bit_inc  = bit_q + BIT_W'(1);
  // rx_prev_q follows rx_s_q in every state, so an edge landing on the
  // cycle the FSM re-enters IDLE is still seen.
  assign fall     = rx_prev_q & ~rx_s_q;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    tick_d       = tick_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    data_d       = data_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        tick_d = '0;
        bit_d  = '0;
        if (fall) state_d = START;
      end
      START: begin
        if (baud_tick) begin
          if (tick_inc == TICK_MID) begin
            tick_d  = '0;
            state_d = rx_s_q ? IDLE : DATA;
          end else begin
            tick_d = tick_inc;
          end
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_inc;
            if (bit_inc == BIT_LAST) state_d = STOP;
          end else begin
            tick_d = tick_inc;
          end
        end
      end
      STOP: begin
        if (baud_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d       = '0;
            bit_d        = '0;
            data_d       = shift_q;
            data_valid_d = rx_s_q;
            frame_err_d  = ~rx_s_q;
            state_d      = IDLE;
          end else begin
            tick_d = tick_inc;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  // NOTE: the shift register and data register are reset as well, so a
  // reset mid-frame leaves no stale partial byte visible on data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q      <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_prev_q    <= 1'b1;
      state_q      <= IDLE;
      tick_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      sync1_q      <= rx;
      rx_s_q       <= sync1_q;
      rx_prev_q    <= rx_s_q;
      state_q      <= state_d;
      tick_q       <= tick_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: good frames, false start, framing error with break,
// back-to-back frames, reset mid-frame and a baud_tick stall.
module tb_uart_rx;

  localparam int DB = 8;
  localparam int OS = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          baud_tick;
  logic          rx;
  logic [DB-1:0] data;
  logic          data_valid;
  logic          frame_err;
  logic          busy;

  int n_vec = 0;
  int n_err = 0;

  int tick_period = 20;
  bit tick_en     = 1'b1;
  int tick_cnt    = 0;

  int            dv_count   = 0;
  int            fe_count   = 0;
  int            both_count = 0;
  int            wide_count = 0;
  logic          prev_dv    = 1'b0;
  logic          prev_fe    = 1'b0;
  logic [DB-1:0] dv_log[$];

  uart_rx #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
    .clk        (clk),
    .reset      (reset),
    .baud_tick  (baud_tick),
    .rx         (rx),
    .data       (data),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Baud generator: one-clock pulse every tick_period clocks; phase freezes while disabled.
  initial begin
    baud_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (tick_en && tick_cnt >= tick_period - 1) begin
        tick_cnt  = 0;
        baud_tick = 1'b1;
      end else begin
        baud_tick = 1'b0;
        if (tick_en) tick_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      dv_count++;
      dv_log.push_back(data);
    end
    if (frame_err === 1'b1) fe_count++;
    if (data_valid === 1'b1 && frame_err === 1'b1) both_count++;
    if ((data_valid === 1'b1 && prev_dv === 1'b1) || (frame_err === 1'b1 && prev_fe === 1'b1))
      wide_count++;
    prev_dv = data_valid;
    prev_fe = frame_err;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b, input int n);
    rx = b;
    wait_clks(n);
  endtask

  task automatic send_frame(input logic [DB-1:0] b, input logic stop);
    drive_bit(1'b0, OS * tick_period);
    for (int i = 0; i < DB; i++) drive_bit(b[i], OS * tick_period);
    drive_bit(stop, OS * tick_period);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    rx    = 1'b1;
    wait_clks(5);
    n_vec++; if (data !== 8'h00) begin n_err++; $display("FAIL reset_data got=%h exp=00", data); end
    n_vec++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL reset_dv got=%b exp=0", data_valid); end
    n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_fe got=%b exp=0", frame_err); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    reset = 1'b1;
    wait_clks(2 * OS * tick_period);
  endtask

  task automatic test_frame_a5;
    int dv0, fe0;
    tick_period = 130;
    wait_clks(OS * tick_period);
    dv0 = dv_count; fe0 = fe_count;
    send_frame(8'hA5, 1'b1);
    n_vec++; if (dv_count - dv0 !== 1) begin n_err++; $display("FAIL a5_dv_pulses got=%0d exp=1", dv_count - dv0); end
    n_vec++; if (fe_count - fe0 !== 0) begin n_err++; $display("FAIL a5_fe_pulses got=%0d exp=0", fe_count - fe0); end
    n_vec++; if (data !== 8'hA5) begin n_err++; $display("FAIL a5_data got=%h exp=a5", data); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL a5_busy_after got=%b exp=0", busy); end
    tick_period = 20;
    wait_clks(2 * OS * tick_period);
  endtask

  task automatic test_glitch;
    int dv0, fe0;
    dv0 = dv_count; fe0 = fe_count;
    rx = 1'b0;
    wait_clks(10);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL glitch_busy_start got=%b exp=1", busy); end
    wait_clks(5 * tick_period - 10);
    rx = 1'b1;
    wait_clks(2 * OS * tick_period);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL glitch_busy_end got=%b exp=0", busy); end
    n_vec++; if ((dv_count - dv0) + (fe_count - fe0) !== 0) begin
      n_err++; $display("FAIL glitch_pulses got=%0d exp=0", (dv_count - dv0) + (fe_count - fe0)); end
    n_vec++; if (data !== 8'hA5) begin n_err++; $display("FAIL glitch_data got=%h exp=a5", data); end
  endtask

  task automatic test_frame_err;
    int dv0, fe0, busy_hits;
    dv0 = dv_count; fe0 = fe_count;
    send_frame(8'h3C, 1'b0);
    n_vec++; if (fe_count - fe0 !== 1) begin n_err++; $display("FAIL ferr_fe_pulses got=%0d exp=1", fe_count - fe0); end
    n_vec++; if (dv_count - dv0 !== 0) begin n_err++; $display("FAIL ferr_dv_pulses got=%0d exp=0", dv_count - dv0); end
    n_vec++; if (data !== 8'h3C) begin n_err++; $display("FAIL ferr_data got=%h exp=3c", data); end
    busy_hits = 0;
    for (int i = 0; i < 3 * OS * tick_period; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) busy_hits++;
    end
    n_vec++; if (busy_hits !== 0) begin n_err++; $display("FAIL break_busy_cycles got=%0d exp=0", busy_hits); end
    n_vec++; if (fe_count - fe0 !== 1) begin n_err++; $display("FAIL break_fe_pulses got=%0d exp=1", fe_count - fe0); end
    drive_bit(1'b1, OS * tick_period);
    send_frame(8'h81, 1'b1);
    n_vec++; if (dv_count - dv0 !== 1) begin n_err++; $display("FAIL after_break_dv got=%0d exp=1", dv_count - dv0); end
    n_vec++; if (data !== 8'h81) begin n_err++; $display("FAIL after_break_data got=%h exp=81", data); end
    wait_clks(OS * tick_period);
  endtask

  task automatic test_back_to_back;
    int dv0, fe0, s;
    logic [DB-1:0] first, second;
    dv0 = dv_count; fe0 = fe_count; s = dv_log.size();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    first  = (dv_log.size() > s)     ? dv_log[s]     : 8'hxx;
    second = (dv_log.size() > s + 1) ? dv_log[s + 1] : 8'hxx;
    n_vec++; if (dv_count - dv0 !== 2) begin n_err++; $display("FAIL b2b_dv_pulses got=%0d exp=2", dv_count - dv0); end
    n_vec++; if (first !== 8'h00) begin n_err++; $display("FAIL b2b_first got=%h exp=00", first); end
    n_vec++; if (second !== 8'hFF) begin n_err++; $display("FAIL b2b_second got=%h exp=ff", second); end
    n_vec++; if (fe_count - fe0 !== 0) begin n_err++; $display("FAIL b2b_fe_pulses got=%0d exp=0", fe_count - fe0); end
    wait_clks(OS * tick_period);
  endtask

  task automatic test_reset_mid;
    int dv0, fe0;
    logic [DB-1:0] b;
    b = 8'h5A;
    drive_bit(1'b0, OS * tick_period);
    for (int i = 0; i < 4; i++) drive_bit(b[i], OS * tick_period);
    drive_bit(b[4], OS * tick_period / 2);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rstmid_busy_before got=%b exp=1", busy); end
    reset = 1'b0;
    #1;
    n_vec++; if (data !== 8'h00) begin n_err++; $display("FAIL rstmid_data got=%h exp=00", data); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    n_vec++; if ({data_valid, frame_err} !== 2'b00) begin
      n_err++; $display("FAIL rstmid_pulses got=%b exp=00", {data_valid, frame_err}); end
    wait_clks(3);
    rx    = 1'b1;
    reset = 1'b1;
    dv0 = dv_count; fe0 = fe_count;
    wait_clks(2 * OS * tick_period);
    n_vec++; if ((dv_count - dv0) + (fe_count - fe0) !== 0 || busy !== 1'b0) begin
      n_err++; $display("FAIL rstmid_quiet got pulses=%0d busy=%b exp=0/0", (dv_count - dv0) + (fe_count - fe0), busy); end
    send_frame(8'h5A, 1'b1);
    n_vec++; if (dv_count - dv0 !== 1) begin n_err++; $display("FAIL rstmid_next_dv got=%0d exp=1", dv_count - dv0); end
    n_vec++; if (data !== 8'h5A) begin n_err++; $display("FAIL rstmid_next_data got=%h exp=5a", data); end
    wait_clks(OS * tick_period);
  endtask

  task automatic test_freeze;
    int dv0, fe0, bad;
    logic [DB-1:0] b;
    b = 8'h96;
    dv0 = dv_count; fe0 = fe_count;
    drive_bit(1'b0, OS * tick_period);
    for (int i = 0; i < 3; i++) drive_bit(b[i], OS * tick_period);
    drive_bit(b[3], OS * tick_period / 2);
    tick_en = 1'b0;
    wait_clks(2);
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (busy !== 1'b1 || data !== 8'h5A || data_valid !== 1'b0 || frame_err !== 1'b0) bad++;
    end
    n_vec++; if (bad !== 0) begin n_err++; $display("FAIL freeze_hold bad_cycles got=%0d exp=0", bad); end
    tick_en = 1'b1;
    wait_clks(OS * tick_period / 2 - 2);
    for (int i = 4; i < DB; i++) drive_bit(b[i], OS * tick_period);
    drive_bit(1'b1, OS * tick_period);
    n_vec++; if (dv_count - dv0 !== 1) begin n_err++; $display("FAIL freeze_dv got=%0d exp=1", dv_count - dv0); end
    n_vec++; if (data !== 8'h96) begin n_err++; $display("FAIL freeze_data got=%h exp=96", data); end
    n_vec++; if (fe_count - fe0 !== 0) begin n_err++; $display("FAIL freeze_fe got=%0d exp=0", fe_count - fe0); end
    wait_clks(OS * tick_period);
  endtask

  task automatic test_pulse_shape;
    n_vec++; if (both_count !== 0) begin n_err++; $display("FAIL pulse_overlap got=%0d exp=0", both_count); end
    n_vec++; if (wide_count !== 0) begin n_err++; $display("FAIL pulse_width got=%0d exp=0", wide_count); end
  endtask

  initial begin
    reset = 1'b0;
    rx    = 1'b1;
    @(negedge clk);
    test_reset;
    test_frame_a5;
    test_glitch;
    test_frame_err;
    test_back_to_back;
    test_reset_mid;
    test_freeze;
    test_pulse_shape;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
